pmt_gate_sequencer: RTL
=======================

PMT_GATE_SEQUENCER -- requirements
Module: pmt_gate_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: port clock (input, 1, rising-edge clock for all logic) and port reset_n (input, 1, asynchronous active-low reset).
REQ-002 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-003 abort  input  1  terminate any sequence; highest priority after reset.
REQ-004 window_len  input  16  gate-high cycles per window; latched on accepted start.
REQ-005 gap_len  input  16  gate-low cycles between windows; latched on accepted start; value 0 SHALL be treated as 1.
REQ-006 num_windows  input  8  windows per sequence; latched on accepted start.
REQ-007 gate  output  1  count enable driving the double-buffered photon counter's count input.
REQ-008 bank_sel  output  1  bank select driving the counter's toggle input; 1 selects bank A, 0 selects bank B.
REQ-009 busy  output  1  high in GATE and GAP states.
REQ-010 bank_ready  output  1  one-cycle pulse: the bank just closed holds a final count.
REQ-011 ready_bank  output  1  bank_sel value of the window just closed; valid while bank_ready=1.
REQ-012 done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-013 States SHALL be IDLE, GATE and GAP, with a 16-bit phase counter and an 8-bit window counter.
REQ-014 Start acceptance: in IDLE, start=1, window_len!=0 and num_windows!=0 SHALL latch parameters and enter GATE on the next edge; otherwise start SHALL be ignored (see REQ-025 for num_windows=0).
REQ-015 gate SHALL be 1 exactly in GATE, for exactly window_len consecutive cycles per window.
REQ-016 bank_sel SHALL be constant for every cycle of a window, and SHALL toggle on the edge leaving GATE.
REQ-017 Leaving GATE, on the first gate-low cycle, the block SHALL pulse bank_ready with ready_bank equal to the closed window's bank_sel (the counter's output is final at that cycle).
REQ-018 GATE→GAP if windows completed < num_windows; GAP lasts max(gap_len,1) cycles, then →GATE.
REQ-019 GATE→IDLE after the last window; done and bank_ready SHALL pulse in the same cycle.
REQ-020 gate SHALL be low at least one cycle between any two windows, including back-to-back sequences, so the counter clears.
REQ-021 abort=1 in any state SHALL force IDLE on the next edge with gate=0; no bank_ready or done for the truncated window; abort and start in the same cycle: abort wins.
REQ-022 Input changes on window_len, gap_len or num_windows while busy SHALL have no effect.
REQ-023 Counters SHALL not wrap: window_len=65535 and num_windows=255 SHALL run to completion exactly.

Reset
REQ-024 While reset_n=0: state IDLE, gate=0, bank_sel=1, busy=0, bank_ready=0, ready_bank=0, done=0, all counters 0; assertion mid-sequence SHALL abandon it without pulses; the first sequence after reset SHALL start on bank A.

Configuration
REQ-025 Macro PMT_GATE_CONTINUOUS_EN: when defined, start with num_windows=0 SHALL run windows indefinitely (never done) until abort or reset; when undefined, start with num_windows=0 SHALL be ignored and the block SHALL remain IDLE.

Verification
REQ-026 window_len=4, gap_len=2, num_windows=3, start pulse → gate high 4 cycles, low 2, repeated 3 times; bank_sel 1,0,1; three bank_ready pulses with ready_bank 1,0,1; done pulses together with the third bank_ready.
REQ-027 gap_len=0, window_len=1, num_windows=2 → gate pattern 1,0,1 then low; two bank_ready pulses; done once.
REQ-028 abort during the 2nd cycle of window 2 of 3 → gate low next cycle, busy=0, no further bank_ready, no done.
REQ-029 start with window_len=0, or with num_windows=0 and macro undefined → no gate, busy stays 0; with PMT_GATE_CONTINUOUS_EN defined, num_windows=0 → more than 10 windows until abort, done never.
REQ-030 reset_n pulsed low mid-GATE → all outputs reach reset values asynchronously; the next start opens bank A (bank_sel=1).

Source files
------------

// File: rtl/pmt_gate_sequencer.sv
// rtl/pmt_gate_sequencer.sv - gate/bank sequencer for a double-buffered photon counter
// Optional macro PMT_GATE_CONTINUOUS_EN: num_windows=0 runs windows until abort or reset.
module pmt_gate_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] window_len,
    input  logic [15:0] gap_len,
    input  logic [7:0]  num_windows,
    output logic        gate,
    output logic        bank_sel,
    output logic        busy,
    output logic        bank_ready,
    output logic        ready_bank,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] phase, phase_next;
    logic [7:0]  wcnt, wcnt_next;
    logic [15:0] win_len_q, gap_q;
    logic [7:0]  num_win_q;
    logic        bank_next, ready_next, rbank_next, done_next;
    logic        latch;
    logic        start_ok;
    logic        last_win;
    logic        continuous;

`ifdef PMT_GATE_CONTINUOUS_EN
    assign start_ok   = start && (window_len != 16'd0);
    assign continuous = (num_win_q == 8'd0);
`else
    assign start_ok   = start && (window_len != 16'd0) && (num_windows != 8'd0);
    assign continuous = 1'b0;
`endif

    assign last_win = !continuous && (wcnt == num_win_q - 8'd1);
    assign gate     = (state == GATE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        phase_next = phase;
        wcnt_next  = wcnt;
        bank_next  = bank_sel;
        ready_next = 1'b0;
        rbank_next = ready_bank;
        done_next  = 1'b0;
        latch      = 1'b0;
        if (abort) begin
            state_next = IDLE;
            phase_next = 16'd0;
            wcnt_next  = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        latch      = 1'b1;
                        state_next = GATE;
                        phase_next = 16'd0;
                        wcnt_next  = 8'd0;
                    end
                end
                GATE: begin
                    if (phase == win_len_q - 16'd1) begin
                        // Closing the window: flip banks and flag the closed one as final.
                        bank_next  = ~bank_sel;
                        ready_next = 1'b1;
                        rbank_next = bank_sel;
                        phase_next = 16'd0;
                        if (last_win) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                            wcnt_next  = 8'd0;
                        end else begin
                            state_next = GAP;
                            wcnt_next  = continuous ? wcnt : wcnt + 8'd1;
                        end
                    end else begin
                        phase_next = phase + 16'd1;
                    end
                end
                GAP: begin
                    if (phase == gap_q - 16'd1) begin
                        state_next = GATE;
                        phase_next = 16'd0;
                    end else begin
                        phase_next = phase + 16'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    phase_next = 16'd0;
                    wcnt_next  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase      <= 16'd0;
            wcnt       <= 8'd0;
            win_len_q  <= 16'd0;
            gap_q      <= 16'd0;
            num_win_q  <= 8'd0;
            bank_sel   <= 1'b1;
            bank_ready <= 1'b0;
            ready_bank <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            wcnt       <= wcnt_next;
            bank_sel   <= bank_next;
            bank_ready <= ready_next;
            ready_bank <= rbank_next;
            done       <= done_next;
            if (latch) begin
                win_len_q <= window_len;
                gap_q     <= (gap_len == 16'd0) ? 16'd1 : gap_len;
                num_win_q <= num_windows;
            end
        end
    end

endmodule
